// File: rtl/prbs_pkg.sv
// Shared PRBS-7 (x^7 + x^6 + 1) definitions: tap positions, checker states
// and the one-step generator function used by the free-running reference.
package prbs_pkg;
    localparam int LEN   = 7;
    localparam int TAP_A = 6;
    localparam int TAP_B = 5;

    typedef enum logic {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    function automatic logic [LEN-1:0] prbs7_next(input logic [LEN-1:0] sr);
        return {sr[LEN-2:0], sr[TAP_A] ^ sr[TAP_B]};
    endfunction
endpackage

// File: rtl/prbs_sat_cnt.sv
// Saturating up-counter with synchronous clear; a clear that coincides with
// an increment leaves the counter at 1 so that event is not lost.
module prbs_sat_cnt #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_inc,
    input  logic         i_clr,
    output logic [W-1:0] o_cnt
);
    localparam logic [W-1:0] MAX_VAL = '1;
    localparam logic [W-1:0] ONE_VAL = {{(W-1){1'b0}}, 1'b1};

    logic [W-1:0] r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= i_inc ? ONE_VAL : '0;
        end else if (i_inc && (r_cnt != MAX_VAL)) begin
            r_cnt <= r_cnt + ONE_VAL;
        end
    end

    assign o_cnt = r_cnt;
endmodule

// File: rtl/prbs7_checker.sv
// PRBS-7 receive checker: self-synchronises in HUNT, then compares the input
// against a free-running reference in LOCKED and counts errors/checked bits.
module prbs7_checker
    import prbs_pkg::*;
#(
    parameter int LOCK_CNT = 16,
    parameter int LOSS_WIN = 128,
    parameter int LOSS_THR = 8,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             din,
    input  logic             din_vld,
    input  logic             clr,
    output logic             locked,
    output logic             err_pulse,
    output logic [CNT_W-1:0] err_cnt,
    output logic [CNT_W-1:0] bit_cnt
);
    localparam int MW = $clog2(LOCK_CNT + 1);
    localparam int WW = (LOSS_WIN > 1) ? $clog2(LOSS_WIN) : 1;
    localparam int EW = (LOSS_THR > 1) ? $clog2(LOSS_THR) : 1;

    localparam logic [2:0]    FILL_DONE  = 3'(LEN);
    localparam logic [MW-1:0] MATCH_LAST = MW'(LOCK_CNT - 1);
    localparam logic [WW-1:0] WIN_LAST   = WW'(LOSS_WIN - 1);
    localparam logic [EW-1:0] ERR_LAST   = EW'(LOSS_THR - 1);

    state_t         r_state;
    state_t         w_state_next;
    logic [LEN-1:0] r_sr;
    logic [2:0]     r_fill;
    logic [MW-1:0]  r_match;
    logic [WW-1:0]  r_win_cnt;
    logic [EW-1:0]  r_win_err;
    logic           r_err_pulse;

    logic w_pred;
    logic w_filled;
    logic w_check;
    logic w_bad;
    logic w_match;
    logic w_lock_hit;
    logic w_loss_hit;
    logic w_wrap;

    // An all-zero register is the PRBS lock-up state, so it never counts as a match.
    always_comb begin
        w_pred     = r_sr[TAP_A] ^ r_sr[TAP_B];
        w_filled   = (r_fill == FILL_DONE);
        w_check    = din_vld && (r_state == LOCKED);
        w_bad      = w_check && (din != w_pred);
        w_match    = din_vld && (r_state == HUNT) && w_filled
                     && (din == w_pred) && (r_sr != '0);
        w_lock_hit = w_match && (r_match == MATCH_LAST);
        w_loss_hit = w_bad && (r_win_err == ERR_LAST);
        w_wrap     = (r_win_cnt == WIN_LAST);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= HUNT;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            HUNT:    if (w_lock_hit) w_state_next = LOCKED;
            LOCKED:  if (w_loss_hit) w_state_next = HUNT;
            default: w_state_next = HUNT;
        endcase
    end

    always_comb begin
        locked    = (r_state == LOCKED);
        err_pulse = r_err_pulse;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sr        <= '0;
            r_fill      <= '0;
            r_match     <= '0;
            r_win_cnt   <= '0;
            r_win_err   <= '0;
            r_err_pulse <= 1'b0;
        end else begin
            r_err_pulse <= w_bad;
            if (din_vld) begin
                if (r_state == HUNT) begin
                    r_sr <= {r_sr[LEN-2:0], din};
                    if (!w_filled) begin
                        r_fill <= r_fill + 3'd1;
                    end else if (w_lock_hit || !w_match) begin
                        r_match <= '0;
                    end else begin
                        r_match <= r_match + 1'b1;
                    end
                    if (w_lock_hit) begin
                        r_win_cnt <= '0;
                        r_win_err <= '0;
                    end
                end else begin
                    // Reference keeps running on its own so bad input bits cannot corrupt it.
                    r_sr      <= prbs7_next(r_sr);
                    r_win_cnt <= w_wrap ? '0 : r_win_cnt + 1'b1;
                    if (w_wrap || w_loss_hit) begin
                        r_win_err <= '0;
                    end else if (w_bad) begin
                        r_win_err <= r_win_err + 1'b1;
                    end
                    if (w_loss_hit) begin
                        r_fill  <= '0;
                        r_match <= '0;
                    end
                end
            end
        end
    end

    prbs_sat_cnt #(.W(CNT_W)) u_err_cnt (
        .clk   (clk),
        .rst   (rst),
        .i_inc (w_bad),
        .i_clr (clr),
        .o_cnt (err_cnt)
    );

    prbs_sat_cnt #(.W(CNT_W)) u_bit_cnt (
        .clk   (clk),
        .rst   (rst),
        .i_inc (w_check),
        .i_clr (clr),
        .o_cnt (bit_cnt)
    );
endmodule

// File: tb/tb_prbs7_checker.sv
// Bench for prbs7_checker: directed phases with randomised seeds/offsets, checked
// beat by beat against a recurrence-based reference model; a 4-bit-counter copy covers saturation.
module tb_prbs7_checker;
    localparam int LOCK_CNT = 16;
    localparam int LOSS_WIN = 128;
    localparam int LOSS_THR = 8;
    localparam int CNT_W    = 16;
    localparam int SMALL_W  = 4;

    logic clk     = 1'b0;
    logic rst     = 1'b1;
    logic din     = 1'b0;
    logic din_vld = 1'b0;
    logic clr     = 1'b0;

    logic               locked, err_pulse;
    logic [CNT_W-1:0]   err_cnt, bit_cnt;
    logic               locked_s, err_pulse_s;
    logic [SMALL_W-1:0] err_cnt_s, bit_cnt_s;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    prbs7_checker #(
        .LOCK_CNT(LOCK_CNT), .LOSS_WIN(LOSS_WIN), .LOSS_THR(LOSS_THR), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst(rst), .din(din), .din_vld(din_vld), .clr(clr),
        .locked(locked), .err_pulse(err_pulse), .err_cnt(err_cnt), .bit_cnt(bit_cnt)
    );

    prbs7_checker #(
        .LOCK_CNT(LOCK_CNT), .LOSS_WIN(LOSS_WIN), .LOSS_THR(LOSS_THR), .CNT_W(SMALL_W)
    ) dut_small (
        .clk(clk), .rst(rst), .din(din), .din_vld(din_vld), .clr(clr),
        .locked(locked_s), .err_pulse(err_pulse_s), .err_cnt(err_cnt_s), .bit_cnt(bit_cnt_s)
    );

    // Reference model: m_ref holds the last seven reference bits, oldest first,
    // so the next PRBS-7 bit is b[n-7] ^ b[n-6] = m_ref[0] ^ m_ref[1].
    bit   m_ref[$];
    bit   m_locked, m_pulse;
    int   m_fill, m_run, m_wpos, m_werr;
    int   m_err, m_bits, m_err_s, m_bits_s;
    logic [6:0] gen_s;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int sat_next(input int cur, input bit inc, input bit c, input int mx);
        if (c) return inc ? 1 : 0;
        if (inc && cur < mx) return cur + 1;
        return cur;
    endfunction

    task automatic model_reset();
        m_ref.delete();
        repeat (7) m_ref.push_back(1'b0);
        m_locked = 0; m_pulse = 0;
        m_fill = 0; m_run = 0; m_wpos = 0; m_werr = 0;
        m_err = 0; m_bits = 0; m_err_s = 0; m_bits_s = 0;
    endtask

    task automatic model_beat(input bit v, input bit d, input bit c);
        bit pred;
        bit inc_err;
        bit inc_bit;
        int ones;
        inc_err = 0; inc_bit = 0; m_pulse = 0;
        if (v) begin
            pred = m_ref[0] ^ m_ref[1];
            ones = 0;
            foreach (m_ref[i]) ones += int'(m_ref[i]);
            if (!m_locked) begin
                if (m_fill < 7) m_fill++;
                else if (d == pred && ones != 0) m_run++;
                else m_run = 0;
                m_ref.push_back(d);
                if (m_run == LOCK_CNT) begin
                    m_locked = 1; m_run = 0; m_wpos = 0; m_werr = 0;
                end
            end else begin
                inc_bit = 1;
                inc_err = (d != pred);
                m_pulse = inc_err;
                m_ref.push_back(pred);
                if (inc_err) m_werr++;
                if (m_werr == LOSS_THR) begin
                    m_locked = 0; m_fill = 0; m_run = 0;
                end else if (m_wpos == LOSS_WIN - 1) begin
                    m_wpos = 0; m_werr = 0;
                end else begin
                    m_wpos++;
                end
            end
            m_ref.delete(0);
        end
        m_err    = sat_next(m_err,    inc_err, c, (1 << CNT_W) - 1);
        m_bits   = sat_next(m_bits,   inc_bit, c, (1 << CNT_W) - 1);
        m_err_s  = sat_next(m_err_s,  inc_err, c, (1 << SMALL_W) - 1);
        m_bits_s = sat_next(m_bits_s, inc_bit, c, (1 << SMALL_W) - 1);
    endtask

    task automatic next_bit(output bit b);
        b = gen_s[6] ^ gen_s[5];
        gen_s = {gen_s[5:0], b};
    endtask

    task automatic beat(input bit v, input bit d, input bit c);
        @(negedge clk);
        din_vld = v; din = d; clr = c;
        @(posedge clk);
        #1;
        model_beat(v, d, c);
        check("locked",      32'(locked),    32'(m_locked));
        check("err_pulse",   32'(err_pulse), 32'(m_pulse));
        check("err_cnt",     32'(err_cnt),   32'(m_err));
        check("bit_cnt",     32'(bit_cnt),   32'(m_bits));
        check("err_cnt_sat", 32'(err_cnt_s), 32'(m_err_s));
        check("bit_cnt_sat", 32'(bit_cnt_s), 32'(m_bits_s));
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; din_vld = 1'b0; din = 1'b0; clr = 1'b0;
        model_reset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        bit b;
        int lock_at;
        int cnt;
        int off;
        int pad;

        // Reset state
        model_reset();
        repeat (2) @(negedge clk);
        check("rst_locked",    32'(locked),    32'd0);
        check("rst_err_pulse", 32'(err_pulse), 32'd0);
        check("rst_err_cnt",   32'(err_cnt),   32'd0);
        check("rst_bit_cnt",   32'(bit_cnt),   32'd0);
        rst = 1'b0;

        // 200 clean beats from seed 7'h01
        gen_s = 7'h01;
        lock_at = 0;
        for (int i = 1; i <= 200; i++) begin
            next_bit(b);
            beat(1'b1, b, 1'b0);
            if (locked === 1'b1 && lock_at == 0) lock_at = i;
        end
        check("clean_lock_beat", 32'(lock_at), 32'd23);
        check("clean_err_cnt",   32'(err_cnt), 32'd0);
        check("clean_bit_cnt",   32'(bit_cnt), 32'd177);

        // Three isolated errors 20 beats apart
        off = int'($urandom_range(0, 19));
        cnt = 0;
        for (int i = 0; i < 60; i++) begin
            next_bit(b);
            beat(1'b1, b ^ (i % 20 == off), 1'b0);
            if (err_pulse === 1'b1) cnt++;
        end
        check("iso_pulses",  32'(cnt),     32'd3);
        check("iso_err_cnt", 32'(err_cnt), 32'd3);
        check("iso_locked",  32'(locked),  32'd1);

        // Clear, align to a fresh window, then eight consecutive errors
        next_bit(b);
        beat(1'b1, b, 1'b1);
        check("clr_err_cnt", 32'(err_cnt), 32'd0);
        pad = (LOSS_WIN - m_wpos) % LOSS_WIN + int'($urandom_range(0, 100));
        repeat (pad) begin
            next_bit(b);
            beat(1'b1, b, 1'b0);
        end
        for (int i = 1; i <= 8; i++) begin
            next_bit(b);
            beat(1'b1, ~b, 1'b0);
            if (i == 7) check("burst_locked_7", 32'(locked), 32'd1);
        end
        check("burst_locked_8", 32'(locked),  32'd0);
        check("burst_err_cnt",  32'(err_cnt), 32'd8);
        lock_at = 0;
        for (int i = 1; i <= 40 && lock_at == 0; i++) begin
            next_bit(b);
            beat(1'b1, b, 1'b0);
            if (locked === 1'b1) lock_at = i;
        end
        check("relock_beats", 32'(lock_at), 32'd23);

        // Constant zero stream never locks
        do_reset();
        cnt = 0;
        repeat (100) begin
            beat(1'b1, 1'b0, 1'b0);
            if (locked !== 1'b0) cnt++;
        end
        check("zero_locked_cycles", 32'(cnt),     32'd0);
        check("zero_err_cnt",       32'(err_cnt), 32'd0);
        check("zero_bit_cnt",       32'(bit_cnt), 32'd0);

        // din_vld toggling with garbage on idle cycles, random seed
        do_reset();
        gen_s = 7'($urandom_range(1, 127));
        lock_at = 0;
        for (int k = 1; k <= 60; k++) begin
            next_bit(b);
            beat(1'b1, b, 1'b0);
            if (locked === 1'b1 && lock_at == 0) lock_at = k;
            beat(1'b0, 1'($urandom), 1'b0);
        end
        check("gap_lock_beat", 32'(lock_at), 32'd23);
        check("gap_err_cnt",   32'(err_cnt), 32'd0);

        // Five errors, then clr together with a sixth
        for (int i = 0; i < 15; i++) begin
            next_bit(b);
            beat(1'b1, b ^ (i % 3 == 0), 1'b0);
        end
        check("five_err_cnt", 32'(err_cnt), 32'd5);
        next_bit(b);
        beat(1'b1, ~b, 1'b1);
        check("clr_with_err", 32'(err_cnt), 32'd1);
        check("clr_locked",   32'(locked),  32'd1);

        // Asynchronous reset mid-lock, observed before the next clock edge
        @(negedge clk);
        next_bit(b);
        din_vld = 1'b1; din = ~b;
        #2 rst = 1'b1;
        #1;
        check("async_locked",    32'(locked),    32'd0);
        check("async_err_pulse", 32'(err_pulse), 32'd0);
        check("async_err_cnt",   32'(err_cnt),   32'd0);
        check("async_bit_cnt",   32'(bit_cnt),   32'd0);
        model_reset();
        @(negedge clk);
        rst = 1'b0; din_vld = 1'b0;
        lock_at = 0;
        for (int i = 1; i <= 30; i++) begin
            next_bit(b);
            beat(1'b1, b, 1'b0);
            if (locked === 1'b1 && lock_at == 0) lock_at = i;
        end
        check("post_rst_lock_beat", 32'(lock_at), 32'd23);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
